// File: rtl/fifo_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_word_serializer                                         |
// | Description : Reads words from a registered-output FIFO and shifts each    |
// |               one out bit-serially on a valid/ready stream.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fifo_word_serializer #(
  parameter int DATA_W    = 32,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_dout,
  output logic              o_fifo_rd,
  output logic              o_ser_out,
  output logic              o_ser_valid,
  input  logic              i_ser_ready,
  output logic              o_ser_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_words_sent
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] c_last_bit = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_CAPTURE = 2'd2,
    S_SHIFT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_next;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]   r_words_sent;
  logic               w_head;
  logic               w_accept;
  logic               w_last_accept;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_head       = r_shift[DATA_W-1];
      assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head       = r_shift[0];
      assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
    end
  endgenerate

  // The next read is decided at the last-bit handshake so back-to-back words
  // only lose the RD_REQ and CAPTURE cycles.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_last_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en && !i_fifo_empty) w_state_next = S_RD_REQ;
      end
      S_RD_REQ: begin
        w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_ser_ready) begin
          w_accept = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_last_accept = 1'b1;
            w_state_next  = (i_en && !i_fifo_empty) ? S_RD_REQ : S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_words_sent <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CAPTURE) begin
        r_shift   <= i_fifo_dout;
        r_bit_cnt <= '0;
      end else if (w_accept) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
      if (w_last_accept) r_words_sent <= r_words_sent + CNT_W'(1);
    end
  end

  assign o_fifo_rd    = (r_state == S_RD_REQ);
  assign o_ser_valid  = (r_state == S_SHIFT);
  assign o_ser_out    = (r_state == S_SHIFT) && w_head;
  assign o_ser_last   = (r_state == S_SHIFT) && (r_bit_cnt == c_last_bit);
  assign o_busy       = (r_state != S_IDLE);
  assign o_words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_word_serializer                                      |
// | Description : Directed bench for fifo_word_serializer, LSB- and MSB-first. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fifo_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic ready = 1'b0;

  logic        a_empty, a_rd, a_out, a_valid, a_last, a_busy;
  logic [31:0] a_dout = '0;
  logic [15:0] a_ws;
  logic        b_empty, b_rd, b_out, b_valid, b_last, b_busy;
  logic [31:0] b_dout = '0;
  logic [15:0] b_ws;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  int wp_a = 0, rp_a = 0, rdcnt_a = 0;
  int wp_b = 0, rp_b = 0, rdcnt_b = 0;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  assign a_empty = (wp_a == rp_a);
  assign b_empty = (wp_b == rp_b);

  // Registered-output FIFO models: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (a_rd) begin
      a_dout  <= mem_a[rp_a % 64];
      rp_a    <= rp_a + 1;
      rdcnt_a <= rdcnt_a + 1;
    end
    if (b_rd) begin
      b_dout  <= mem_b[rp_b % 64];
      rp_b    <= rp_b + 1;
      rdcnt_b <= rdcnt_b + 1;
    end
  end

  fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(0), .CNT_W(16)) u_dut_lsb (
    .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(a_empty), .i_fifo_dout(a_dout),
    .o_fifo_rd(a_rd), .o_ser_out(a_out), .o_ser_valid(a_valid), .i_ser_ready(ready),
    .o_ser_last(a_last), .o_busy(a_busy), .o_words_sent(a_ws)
  );

  fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(1), .CNT_W(16)) u_dut_msb (
    .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(b_empty), .i_fifo_dout(b_dout),
    .o_fifo_rd(b_rd), .o_ser_out(b_out), .o_ser_valid(b_valid), .i_ser_ready(ready),
    .o_ser_last(b_last), .o_busy(b_busy), .o_words_sent(b_ws)
  );

  task automatic push_a(input logic [31:0] d);
    mem_a[wp_a % 64] = d;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [31:0] d);
    mem_b[wp_b % 64] = d;
    wp_b = wp_b + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives ready from a 4-cycle pattern and reassembles one word; called at
  // a falling edge where the first bit is presented.
  task automatic recv(input bit sel, input bit msb, input logic [3:0] rpat,
                      input int drop_en_at, output logic [31:0] w, output int cyc,
                      output int lasterr, output int holderr, output bit tmo);
    int nb;
    logic v, o, l, pv, pr, po, pl;
    nb = 0; w = '0; cyc = 0; lasterr = 0; holderr = 0;
    pv = 1'b0; pr = 1'b1; po = 1'b0; pl = 1'b0;
    for (int k = 0; k < 400 && nb < 32; k++) begin
      if (nb == drop_en_at) en = 1'b0;
      ready = rpat[k % 4];
      v = sel ? b_valid : a_valid;
      o = sel ? b_out   : a_out;
      l = sel ? b_last  : a_last;
      if (pv && !pr && (v !== pv || o !== po || l !== pl)) holderr++;
      if (v !== 1'b1) holderr++;
      if (l !== (nb == 31)) lasterr++;
      if (v === 1'b1 && ready) begin
        if (msb) w = {w[30:0], o};
        else     w[nb] = o;
        nb++;
      end
      pv = v; pr = ready; po = o; pl = l;
      cyc++;
      @(negedge clk);
    end
    tmo = (nb < 32);
  endtask

  task automatic test_reset();
    int bad_rd, bad_v, bad_b;
    do_reset();
    n_total++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid); else n_pass++;
    n_total++; if (a_last !== 1'b0) $display("FAIL reset_last: got %b want 0", a_last); else n_pass++;
    n_total++; if (a_out !== 1'b0) $display("FAIL reset_out: got %b want 0", a_out); else n_pass++;
    n_total++; if (a_ws !== 16'd0) $display("FAIL reset_ws: got %0d want 0", a_ws); else n_pass++;
    en = 1'b1;
    bad_rd = 0; bad_v = 0; bad_b = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_rd !== 1'b0) bad_rd++;
      if (a_valid !== 1'b0) bad_v++;
      if (a_busy !== 1'b0) bad_b++;
    end
    n_total++; if (bad_rd != 0) $display("FAIL idle_rd: got %0d strobes want 0", bad_rd); else n_pass++;
    n_total++; if (bad_v != 0) $display("FAIL idle_valid: got %0d valid cycles want 0", bad_v); else n_pass++;
    n_total++; if (bad_b != 0) $display("FAIL idle_busy: got %0d busy cycles want 0", bad_b); else n_pass++;
    n_total++; if (a_ws !== 16'd0) $display("FAIL idle_ws: got %0d want 0", a_ws); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] w; int cyc, le, he; bit tmo; int base;
    do_reset();
    base = rdcnt_a;
    en = 1'b1; ready = 1'b1;
    push_a(32'hA5A5_0001);
    @(negedge clk);
    n_total++; if (a_rd !== 1'b1) $display("FAIL single_rd_t1: got %b want 1", a_rd); else n_pass++;
    @(negedge clk);
    n_total++; if (a_valid !== 1'b0 || a_busy !== 1'b1 || a_rd !== 1'b0)
      $display("FAIL single_capture: valid=%b busy=%b rd=%b want 0 1 0", a_valid, a_busy, a_rd); else n_pass++;
    @(negedge clk);
    n_total++; if (a_valid !== 1'b1 || a_out !== 1'b1)
      $display("FAIL single_first_bit: valid=%b out=%b want 1 1", a_valid, a_out); else n_pass++;
    recv(1'b0, 1'b0, 4'b1111, -1, w, cyc, le, he, tmo);
    n_total++; if (tmo) $display("FAIL single_timeout: got timeout want 32 bits"); else n_pass++;
    n_total++; if (w !== 32'hA5A5_0001) $display("FAIL single_word: got %h want a5a50001", w); else n_pass++;
    n_total++; if (cyc != 32) $display("FAIL single_cycles: got %0d want 32", cyc); else n_pass++;
    n_total++; if (le != 0 || he != 0) $display("FAIL single_last_hold: got last_err=%0d hold_err=%0d want 0 0", le, he); else n_pass++;
    n_total++; if (a_valid !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL single_end_idle: valid=%b busy=%b want 0 0", a_valid, a_busy); else n_pass++;
    n_total++; if (a_ws !== 16'd1 || rdcnt_a - base != 1)
      $display("FAIL single_counts: ws=%0d rd=%0d want 1 1", a_ws, rdcnt_a - base); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w; int cyc, le, he, gap, gap_err, word_err, misc_err; bit tmo; int base;
    do_reset();
    base = rdcnt_a;
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) push_a(32'(i));
    repeat (3) @(negedge clk);
    gap_err = 0; word_err = 0; misc_err = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        gap = 0;
        while (a_valid !== 1'b1 && gap < 10) begin gap++; @(negedge clk); end
        if (gap != 2) begin
          gap_err++;
          $display("FAIL b2b_gap: word %0d got gap %0d want 2", i, gap);
        end
      end
      recv(1'b0, 1'b0, 4'b1111, -1, w, cyc, le, he, tmo);
      if (w !== 32'(i)) begin
        word_err++;
        $display("FAIL b2b_word: word %0d got %h want %h", i, w, 32'(i));
      end
      if (tmo || le != 0 || he != 0) misc_err++;
    end
    n_total++; if (gap_err != 0) $display("FAIL b2b_gaps: got %0d bad gaps want 0", gap_err); else n_pass++;
    n_total++; if (word_err != 0) $display("FAIL b2b_words: got %0d bad words want 0", word_err); else n_pass++;
    n_total++; if (misc_err != 0) $display("FAIL b2b_protocol: got %0d bad words want 0", misc_err); else n_pass++;
    n_total++; if (rdcnt_a - base != 5) $display("FAIL b2b_rd_count: got %0d want 5", rdcnt_a - base); else n_pass++;
    n_total++; if (a_ws !== 16'd5) $display("FAIL b2b_ws: got %0d want 5", a_ws); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL b2b_final_idle: busy=%b want 0", a_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w; int cyc, le, he; bit tmo;
    do_reset();
    en = 1'b1; ready = 1'b1;
    push_a(32'hFFFF_0000);
    repeat (3) @(negedge clk);
    recv(1'b0, 1'b0, 4'b1001, -1, w, cyc, le, he, tmo);
    n_total++; if (tmo) $display("FAIL bp_timeout: got timeout want 32 bits"); else n_pass++;
    n_total++; if (w !== 32'hFFFF_0000) $display("FAIL bp_word: got %h want ffff0000", w); else n_pass++;
    n_total++; if (cyc != 64) $display("FAIL bp_cycles: got %0d want 64", cyc); else n_pass++;
    n_total++; if (he != 0 || le != 0) $display("FAIL bp_hold: got hold_err=%0d last_err=%0d want 0 0", he, le); else n_pass++;
    n_total++; if (a_ws !== 16'd1) $display("FAIL bp_ws: got %0d want 1", a_ws); else n_pass++;
  endtask

  task automatic test_en_gating();
    logic [31:0] w; int cyc, le, he, base, bad_rd; bit tmo;
    do_reset();
    base = rdcnt_a;
    en = 1'b1; ready = 1'b1;
    push_a(32'h1234_5678);
    push_a(32'h9ABC_DEF0);
    repeat (3) @(negedge clk);
    recv(1'b0, 1'b0, 4'b1111, 10, w, cyc, le, he, tmo);
    n_total++; if (w !== 32'h1234_5678 || tmo) $display("FAIL en_word1: got %h want 12345678", w); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL en_idle_after_word1: busy=%b want 0", a_busy); else n_pass++;
    bad_rd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_rd !== 1'b0) bad_rd++;
    end
    n_total++; if (bad_rd != 0 || rdcnt_a - base != 1)
      $display("FAIL en_no_read: got strobes=%0d total=%0d want 0 1", bad_rd, rdcnt_a - base); else n_pass++;
    en = 1'b1;
    @(negedge clk);
    n_total++; if (a_rd !== 1'b1) $display("FAIL en_resume_rd: got %b want 1", a_rd); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (a_valid !== 1'b1) $display("FAIL en_resume_valid: got %b want 1", a_valid); else n_pass++;
    recv(1'b0, 1'b0, 4'b1111, -1, w, cyc, le, he, tmo);
    n_total++; if (w !== 32'h9ABC_DEF0 || tmo) $display("FAIL en_word2: got %h want 9abcdef0", w); else n_pass++;
    n_total++; if (a_ws !== 16'd2) $display("FAIL en_ws: got %0d want 2", a_ws); else n_pass++;
  endtask

  task automatic test_reset_msb();
    logic [31:0] w; int cyc, le, he, base; bit tmo;
    logic [4:0] head;
    do_reset();
    base = rdcnt_b;
    en = 1'b1; ready = 1'b1;
    push_b(32'h8000_0001);
    repeat (3) @(negedge clk);
    head = '0;
    for (int i = 0; i < 5; i++) begin
      head = {head[3:0], b_out};
      @(negedge clk);
    end
    n_total++; if (head !== 5'b10000) $display("FAIL msb_head_bits: got %b want 10000", head); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (b_valid !== 1'b0 || b_last !== 1'b0 || b_out !== 1'b0 || b_busy !== 1'b0 || b_rd !== 1'b0)
      $display("FAIL midword_reset_outputs: valid=%b last=%b out=%b busy=%b rd=%b want all 0",
               b_valid, b_last, b_out, b_busy, b_rd); else n_pass++;
    n_total++; if (b_ws !== 16'd0) $display("FAIL midword_reset_ws: got %0d want 0", b_ws); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (rdcnt_b - base != 1 || b_busy !== 1'b0)
      $display("FAIL midword_no_reread: reads=%0d busy=%b want 1 0", rdcnt_b - base, b_busy); else n_pass++;
    push_b(32'h8000_0001);
    repeat (3) @(negedge clk);
    n_total++; if (b_valid !== 1'b1 || b_out !== 1'b1)
      $display("FAIL msb_first_bit: valid=%b out=%b want 1 1", b_valid, b_out); else n_pass++;
    recv(1'b1, 1'b1, 4'b1111, -1, w, cyc, le, he, tmo);
    n_total++; if (w !== 32'h8000_0001 || tmo) $display("FAIL msb_word: got %h want 80000001", w); else n_pass++;
    n_total++; if (le != 0 || he != 0) $display("FAIL msb_last_hold: got last_err=%0d hold_err=%0d want 0 0", le, he); else n_pass++;
    n_total++; if (b_ws !== 16'd1) $display("FAIL msb_ws: got %0d want 1", b_ws); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_en_gating();
    test_reset_msb();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Read-side consumer for the 32-bit word FIFO.
- Monitors FIFO EMPTY, issues single-cycle read strobes, and captures the registered FIFO output.
- Shifts each captured word out one bit at a time on a valid/ready serial stream.
- Sits between the FIFO read port and a bit-serial link or transmitter; it must be the only agent driving the FIFO read strobe.

Parameters:
- DATA_W, 32, word width; must match the FIFO data width.
- MSB_FIRST, 0, 0 = bit 0 shifted first; 1 = bit DATA_W-1 shifted first.
- CNT_W, 16, width of the sent-word counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; gates only the start of new FIFO reads.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_dout  in  DATA_W  FIFO registered read data; valid the cycle after a read strobe.
- fifo_rd  out  1  FIFO read strobe, one cycle per word.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out is valid.
- ser_ready  in  1  downstream accepts the bit on a cycle where ser_valid && ser_ready.
- ser_last  out  1  high with the final bit of a word.
- busy  out  1  high whenever state != IDLE.
- words_sent  out  CNT_W  count of fully shifted words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - fifo_rd=0, ser_valid=0, ser_last=0, ser_out=0, busy=0, words_sent=0.
  - Shift register and bit counter cleared.
  - rst overrides all other inputs.
  - Reset mid-word discards the in-flight word; it is not re-read and not counted.
- FSM is Moore-style; all outputs are registered or decoded from state only. States:
  - IDLE: if en && !fifo_empty -> RD_REQ; else stay.
  - RD_REQ: fifo_rd=1 for exactly this cycle -> CAPTURE. Sole-reader rule: EMPTY cannot assert between the IDLE check and RD_REQ.
  - CAPTURE: latch fifo_dout into the shift register; bit_cnt=0 -> SHIFT.
  - SHIFT: ser_valid=1; ser_out = shift-register head (LSB or MSB per MSB_FIRST).
    - On ser_valid && ser_ready: advance shift, bit_cnt+1.
    - ser_last=1 while bit_cnt==DATA_W-1.
    - When the last bit is accepted: words_sent+1, then go to RD_REQ if en && !fifo_empty, else IDLE.
- Backpressure: while ser_ready=0 in SHIFT, ser_out, ser_valid and ser_last hold stable. No bit is dropped or duplicated.
- Latency:
  - First cycle IDLE sees en=1 and fifo_empty=0 is cycle T.
  - fifo_rd=1 in T+1.
  - Capture in T+2.
  - First ser_valid in T+3.
- Throughput:
  - With ser_ready tied to 1, a word occupies DATA_W SHIFT cycles.
  - Back-to-back words have exactly 2 non-valid cycles between them (RD_REQ, CAPTURE).
- en:
  - Dropping en mid-word does not stall the shift; the current word completes.
  - No new fifo_rd is issued while en=0.
  - Sampled in IDLE and at the last-bit handshake.
- fifo_rd is never asserted in IDLE, CAPTURE or SHIFT, and never when fifo_empty was 1 at the deciding edge.
- words_sent rolls from 2^CNT_W-1 to 0 without a flag.
- busy=1 in RD_REQ, CAPTURE and SHIFT.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then fifo_empty=1, en=1 for 10 cycles.
  - Required: fifo_rd never 1, ser_valid=0, busy=0, words_sent=0.
- Single word LSB-first:
  - Stimulus: FIFO holds 32'hA5A5_0001, ser_ready=1.
  - Required: fifo_rd pulses once at T+1; ser_valid from T+3 for 32 cycles; bit stream 1,0,0,... ending with the MSB 1; ser_last only on the 32nd bit; words_sent=1.
- Back-to-back words:
  - Stimulus: FIFO holds 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, en=1, ser_ready=1.
  - Required: five fifo_rd pulses; exactly 2 non-valid cycles between words; reassembled words match in order; words_sent=5; final state IDLE once EMPTY.
- Backpressure:
  - Stimulus: word 32'hFFFF_0000 with ser_ready toggling 1,0,0,1,...
  - Required: ser_out stable whenever ser_ready=0; exactly 32 accepted bits reassemble to 32'hFFFF_0000.
- en gating:
  - Stimulus: two words queued; en deasserted at bit 10 of word 1.
  - Required: word 1 completes; no second fifo_rd while en=0; reasserting en starts word 2 three cycles later.
- Reset mid-word and MSB_FIRST:
  - Stimulus: rst at bit 5 of word 32'h8000_0001, with MSB_FIRST=1.
  - Required: outputs at reset values the next cycle and words_sent=0.
  - Follow-up: re-run without reset; first bit=1, last bit=1, and the stream equals the MSB-first order.
